// File: rtl/reg_wb_ctrl.sv
// Writeback initiator: accepts ALU/LSU results into an in-order queue and drains it into the
// register file write port. Define REG_WB_BYPASS_EN to add q_data (newest queued value for q_addr).
module reg_wb_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter bit ZERO_DROP  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_WIDTH-1:0]   alu_addr,
  input  logic [WIDTH-1:0]        alu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [WIDTH-1:0]        lsu_data,
  input  logic                    hold,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   addrw,
  output logic [WIDTH-1:0]        dinw,
  input  logic [ADDR_WIDTH-1:0]   q_addr,
  output logic                    q_pend,
`ifdef REG_WB_BYPASS_EN
  output logic [WIDTH-1:0]        q_data,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               not_full;
  logic               push_fire;
  logic               push_keep;
  logic               pop;
  entry_t             push_entry;

  // Full is judged on registered count only, so a same-cycle pop never opens a slot.
  assign not_full  = count < CNT_W'(DEPTH);
  assign lsu_ready = !rst && not_full;
  assign alu_ready = !rst && not_full && !lsu_valid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    push_fire  = 1'b0;
    push_entry = '0;
    if (lsu_valid && lsu_ready) begin
      push_fire  = 1'b1;
      push_entry = '{addr: lsu_addr, data: lsu_data};
    end else if (alu_valid && alu_ready) begin
      push_fire  = 1'b1;
      push_entry = '{addr: alu_addr, data: alu_data};
    end
  end

  // x0 writes still complete their handshake but never occupy a slot.
  assign push_keep = push_fire && !(ZERO_DROP && push_entry.addr == '0);
  assign pop       = we;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        vld[rd_ptr] <= 1'b0;
      end
      if (push_keep) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        vld[wr_ptr] <= 1'b1;
      end
      case ({push_keep, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the valid bits and count alone define what is live.
  always_ff @(posedge clk) begin
    if (push_keep) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    we    = (count != '0) && !hold;
    addrw = '0;
    dinw  = '0;
    if (count != '0) begin
      addrw = mem[rd_ptr].addr;
      dinw  = mem[rd_ptr].data;
    end
  end

  always_comb begin
    q_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i].addr == q_addr) q_pend = 1'b1;
    end
    if (ZERO_DROP && q_addr == '0) q_pend = 1'b0;
  end

`ifdef REG_WB_BYPASS_EN
  // Scan oldest to newest from the head so the youngest match overwrites older ones.
  always_comb begin
    q_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[rd_ptr + PTR_W'(i)] && mem[rd_ptr + PTR_W'(i)].addr == q_addr)
        q_data = mem[rd_ptr + PTR_W'(i)].data;
    end
    if (!q_pend) q_data = '0;
  end
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: a negedge monitor models the queue and checks every cycle,
// while directed tests compare the committed-write log against hand-computed sequences.
module tb_reg_wb_ctrl;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  typedef logic [AW+WIDTH-1:0] wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, lsu_valid, hold;
  logic             alu_ready, lsu_ready;
  logic [AW-1:0]    alu_addr, lsu_addr, q_addr, addrw;
  logic [WIDTH-1:0] alu_data, lsu_data, dinw;
  logic             we, q_pend;
  logic [2:0]       count;
`ifdef REG_WB_BYPASS_EN
  logic [WIDTH-1:0] q_data;
`endif

  reg_wb_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ZERO_DROP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .hold(hold), .we(we), .addrw(addrw), .dinw(dinw),
    .q_addr(q_addr), .q_pend(q_pend),
`ifdef REG_WB_BYPASS_EN
    .q_data(q_data),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  acc      = 0;   // 0 none, 1 alu, 2 lsu accepted on the coming edge
  wr_t exp_q[$];
  wr_t log_q[$];
  wr_t exp_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Model of the queue, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit  exp_rdy, exp_we;
    wr_t e;
    if (rst) begin
      check("rst_we", we, 0);
      check("rst_lsu_ready", lsu_ready, 0);
      check("rst_alu_ready", alu_ready, 0);
      check("rst_count", count, 0);
      exp_q.delete();
      acc = 0;
    end else begin
      exp_rdy = exp_q.size() < DEPTH;
      exp_we  = exp_q.size() != 0 && !hold;
      check("lsu_ready", lsu_ready, exp_rdy);
      check("alu_ready", alu_ready, exp_rdy && !lsu_valid);
      check("count", count, exp_q.size());
      check("we", we, exp_we);
      if (exp_we) begin
        e = exp_q.pop_front();
        check("addrw", addrw, e[AW+WIDTH-1:WIDTH]);
        check("dinw", dinw, e[WIDTH-1:0]);
        log_q.push_back({addrw, dinw});
      end
      acc = 0;
      if (exp_rdy && lsu_valid) begin
        acc = 2;
        if (lsu_addr != 0) exp_q.push_back({lsu_addr, lsu_data});
      end else if (exp_rdy && alu_valid) begin
        acc = 1;
        if (alu_addr != 0) exp_q.push_back({alu_addr, alu_data});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic wait_acc(input int kind, input string name);
    bit done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (acc == kind) begin done = 1'b1; break; end
    end
    #1;
    if (!done) timeout(name);
  endtask

  task automatic send(input bit is_lsu, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (is_lsu) begin lsu_valid = 1'b1; lsu_addr = a; lsu_data = d; end
    else        begin alu_valid = 1'b1; alu_addr = a; alu_data = d; end
    wait_acc(is_lsu ? 2 : 1, "send_accept");
    lsu_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && count == 0) begin done = 1'b1; break; end
    end
    if (!done) timeout("drain");
  endtask

  task automatic add(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    exp_log.push_back({a, d});
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, log_q.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp_log[i]);
    log_q.delete();
    exp_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; hold = 1'b0; q_addr = '0;
    alu_addr = '0; alu_data = '0; lsu_addr = '0; lsu_data = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Reset pulse mid-cycle, then idle.
    @(posedge clk); #3 rst = 1'b1; #4 rst = 1'b0;
    @(negedge clk);
    check("idle_count", count, 0);
    check("idle_lsu_ready", lsu_ready, 1);
    check("idle_alu_ready", alu_ready, 1);
    check("idle_we", we, 0);
    @(posedge clk); #1;

    // Reset while an entry is queued discards it.
    hold = 1'b1;
    send(1'b0, 5'd3, 32'h11);
    #2 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0; hold = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_drop_count", count, 0);
    check_log("rst_drop");

    // Single ALU write: visible the cycle after acceptance.
    send(1'b0, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("single_we", we, 1);
    check("single_addrw", addrw, 5);
    check("single_dinw", dinw, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_count", count, 0);
    @(posedge clk); #1;
    add(5'd5, 32'hDEADBEEF);
    check_log("single");

    // Simultaneous requests: LSU first.
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'hB;
    @(negedge clk);
    check("sim_alu_ready", alu_ready, 0);
    check("sim_lsu_ready", lsu_ready, 1);
    @(posedge clk);
    check("sim_lsu_first", acc, 2);
    #1 lsu_valid = 1'b0;
    @(posedge clk);
    check("sim_alu_second", acc, 1);
    #1 alu_valid = 1'b0;
    wait_idle();
    add(5'd4, 32'hB); add(5'd2, 32'hA);
    check_log("sim");

    // Full / backpressure.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) send(1'b0, AW'(i), 32'h100 + i);
    @(negedge clk);
    check("full_count", count, 4);
    check("full_alu_ready", alu_ready, 0);
    check("full_lsu_ready", lsu_ready, 0);
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    @(posedge clk);
    check("full_wait", acc, 0);
    #1 hold = 1'b0;
    wait_acc(1, "full_fifth");
    alu_valid = 1'b0;
    wait_idle();
    for (int i = 1; i <= 4; i++) add(AW'(i), 32'h100 + i);
    add(5'd9, 32'h99);
    check_log("full");

    // x0 write: handshake only.
    send(1'b0, 5'd0, 32'h55);
    repeat (3) @(posedge clk);
    #1;
    check("x0_count", count, 0);
    check_log("x0");

    // Hazard lookup with two writes to reg7 and one to reg8.
    hold = 1'b1;
    send(1'b0, 5'd7, 32'h1);
    send(1'b1, 5'd8, 32'h33);
    send(1'b0, 5'd7, 32'h2);
    q_addr = 5'd7;
    @(negedge clk);
    check("haz_pend7", q_pend, 1);
`ifdef REG_WB_BYPASS_EN
    check("haz_data7", q_data, 32'h2);
`endif
    q_addr = 5'd8; #1;
    check("haz_pend8", q_pend, 1);
`ifdef REG_WB_BYPASS_EN
    check("haz_data8", q_data, 32'h33);
`endif
    q_addr = 5'd3; #1;
    check("haz_pend3", q_pend, 0);
`ifdef REG_WB_BYPASS_EN
    check("haz_data3", q_data, 32'h0);
`endif
    q_addr = 5'd0; #1;
    check("haz_pend0", q_pend, 0);
    @(posedge clk); #1 hold = 1'b0;
    wait_idle();
    q_addr = 5'd7; #1;
    check("haz_pend_after", q_pend, 0);
    add(5'd7, 32'h1); add(5'd8, 32'h33); add(5'd7, 32'h2);
    check_log("haz");

    // Push/pop overlap at count 2.
    hold = 1'b1;
    send(1'b0, 5'd20, 32'h20);
    send(1'b0, 5'd21, 32'h21);
    hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_addr = AW'(10 + i); alu_data = 32'h1000 + i;
      @(negedge clk);
      check("overlap_count", count, 2);
      @(posedge clk);
      check("overlap_acc", acc, 1);
      #1;
    end
    alu_valid = 1'b0;
    wait_idle();
    add(5'd20, 32'h20); add(5'd21, 32'h21);
    for (int i = 0; i < 6; i++) add(AW'(10 + i), 32'h1000 + i);
    check_log("overlap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
Writeback initiator for the NPC general-purpose register file. It collects writeback results from the ALU and LSU via valid/ready handshakes and buffers them in a small in-order queue. It drains the queue by driving the register file's write port (we/addrw/dinw) at most one entry per cycle. It also provides a pending-write lookup so decode can stall on RAW hazards.

Parameters:
WIDTH, 32, data width of one register
ADDR_WIDTH, 5, register address width
DEPTH, 4, queue entries; power of two, >= 2
ZERO_DROP, 1, 1 = writes to address 0 are accepted but never queued

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_addr  in  ADDR_WIDTH  ALU destination register
alu_data  in  WIDTH  ALU result
lsu_valid  in  1  LSU writeback request
lsu_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_WIDTH  LSU destination register
lsu_data  in  WIDTH  LSU load data
hold  in  1  1 = do not drain this cycle
we  out  1  register file write enable
addrw  out  ADDR_WIDTH  register file write address
dinw  out  WIDTH  register file write data
q_addr  in  ADDR_WIDTH  pending-lookup address
q_pend  out  1  1 = a queued entry targets q_addr
count  out  $clog2(DEPTH)+1  queued entries

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, all entry valid bits cleared. Outputs go to we=0, addrw=0, dinw=0, q_pend=0, alu_ready=0, lsu_ready=0. Reset asserted mid-operation discards all queued entries. No write is issued on that edge or afterwards until new pushes occur.
- Arbitration: at most one push per cycle, with fixed LSU priority.
  - lsu_ready = !rst && (count<DEPTH).
  - alu_ready = !rst && (count<DEPTH) && !lsu_valid.
- Full condition uses registered count only: a pop in the same cycle does not open a slot. There is no pass-through.
- Push occurs on a rising edge when valid&&ready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- With ZERO_DROP=1 and addr==0, the handshake completes (ready as above) but nothing is queued, and count is unchanged.
- Drain is driven purely from registered state, with no input-to-output path except hold:
  - we = (count!=0) && !hold.
  - addrw and dinw = head entry while count!=0, else 0.
- Pop occurs on an edge when we=1; rd_ptr increments modulo DEPTH.
- Latency: a request accepted on edge N appears as we=1 in the cycle after edge N, provided the queue was empty and hold=0. Minimum accept-to-regfile-update time is 2 edges.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds DEPTH and never underflows.
- Ordering: strictly FIFO. Two writes to the same register commit in acceptance order.
- q_pend: combinational OR over valid entries of (entry.addr==q_addr). q_pend=0 for q_addr==0 when ZERO_DROP=1.
- Pointer wrap: ptr width is $clog2(DEPTH) and wraps naturally; full/empty are decided by count alone.

Optional Feature:
REG_WB_BYPASS_EN
- Defined: adds output q_data[WIDTH-1:0]. It carries the data of the youngest valid entry whose addr==q_addr (newest wins), or 0 when q_pend=0. Decode may forward this value instead of stalling.
- Undefined: the q_data port does not exist, and no youngest-match priority logic is built. q_pend behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> we=0, count=0, both ready=1 after release. Push alu(addr=3,data=0x11), assert rst before drain -> no write of reg3 occurs.
- Single ALU write: alu_valid addr=5 data=0xDEADBEEF accepted edge N -> cycle after N: we=1, addrw=5, dinw=0xDEADBEEF; count returns to 0 after next edge.
- Simultaneous requests: alu(2,0xA) and lsu(4,0xB) valid together -> lsu accepted first, alu_ready=0 that cycle. alu accepted next cycle; writes drain as reg4=0xB then reg2=0xA.
- Full/backpressure: hold=1, push 4 entries (addrs 1..4) -> count=4, both ready=0. A 5th request waits. Release hold -> drains 1,2,3,4 in order and the 5th is accepted once count<4.
- x0 and hazard lookup: push (0,0x55) -> handshake completes, count stays 0, we never asserts. Push (7,0x1) then (7,0x2) with hold=1 -> q_addr=7 gives q_pend=1, and with REG_WB_BYPASS_EN q_data=0x2.
- Push/pop overlap: queue at count=2 with hold=0 and a continuous ALU stream -> count holds at 2 on each push+pop edge, with no entry lost or duplicated.
